// File: rtl/frame_scrambler_if.sv
// Symbol stream bundle for frame_scrambler.
// Carries both the upstream (i_*) and downstream (o_* / i_ready) handshakes.
//   slave  : scrambler view (consumes i_*, produces o_*)
//   master : environment view (produces i_*, consumes o_*)
// Ports of the bundle:
//   i_data[1:0], i_sof, i_bypass, i_valid, o_ready   upstream symbol channel
//   o_data[1:0], o_sof, o_eof, o_valid, i_ready      downstream symbol channel
interface frame_scrambler_if;
    logic [1:0] i_data;
    logic       i_sof;
    logic       i_bypass;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] o_data;
    logic       o_sof;
    logic       o_eof;
    logic       o_valid;
    logic       i_ready;

    modport slave (
        input  i_data, i_sof, i_bypass, i_valid, i_ready,
        output o_ready, o_data, o_sof, o_eof, o_valid
    );

    modport master (
        output i_data, i_sof, i_bypass, i_valid, i_ready,
        input  o_ready, o_data, o_sof, o_eof, o_valid
    );
endinterface

// File: rtl/frame_scrambler.sv
// Frame scrambler: passes each frame's attached sync marker through unchanged and XORs
// every payload symbol with the 2-bit randomizer symbol. Drives the randomizer reset and
// step enable so each payload starts from the randomizer's initial state.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   bus              symbol stream bundle (slave side), single registered output stage
//   i_r              current randomizer symbol
//   o_rand_rst       synchronous reset request to the randomizer
//   o_rand_en        step the randomizer at this clock edge
//   o_drop           pulse: a non-sof symbol was discarded while idle
//   o_sof_err        pulse: sof arrived before the current frame completed
module frame_scrambler #(
    parameter int unsigned ASM_SYMS     = 16,
    parameter int unsigned PAYLOAD_SYMS = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    frame_scrambler_if.slave      bus,
    input  logic [1:0]            i_r,
    output logic                  o_rand_rst,
    output logic                  o_rand_en,
    output logic                  o_drop,
    output logic                  o_sof_err
);

    localparam int unsigned MaxSyms = (ASM_SYMS > PAYLOAD_SYMS) ? ASM_SYMS : PAYLOAD_SYMS;
    localparam int unsigned CntW    = $clog2(MaxSyms + 1);

    typedef enum logic [1:0] {StIdle, StAsm, StPayload} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              bypass_q, bypass_d;
    logic              rst_pending_q;
    logic [1:0]        data_q, data_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              accept;

    assign bus.o_ready = !valid_q | bus.i_ready;
    assign accept      = bus.i_valid & bus.o_ready;
    assign cnt_inc     = cnt_q + CntW'(1);

    // Randomizer only steps on scrambled payload symbols; a sof always restarts it.
    assign o_rand_en  = accept & (state_q == StPayload) & !bypass_q & !bus.i_sof;
    assign o_rand_rst = (accept & bus.i_sof) | rst_pending_q;

    assign bus.o_data  = data_q;
    assign bus.o_sof   = sof_q;
    assign bus.o_eof   = eof_q;
    assign bus.o_valid = valid_q;
    assign o_drop      = drop_q;
    assign o_sof_err   = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bypass_d = bypass_q;
        data_d   = data_q;
        sof_d    = sof_q;
        eof_d    = eof_q;
        valid_d  = valid_q & !bus.i_ready;
        drop_d   = 1'b0;
        err_d    = 1'b0;

        if (accept) begin
            if (bus.i_sof) begin
                // sof wins in every state, including on the would-be last payload symbol.
                err_d    = (state_q != StIdle);
                bypass_d = bus.i_bypass;
                data_d   = bus.i_data;
                sof_d    = 1'b1;
                eof_d    = 1'b0;
                valid_d  = 1'b1;
                if (ASM_SYMS == 1) begin
                    state_d = StPayload;
                    cnt_d   = '0;
                end else begin
                    state_d = StAsm;
                    cnt_d   = CntW'(1);
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        drop_d = 1'b1;
                    end
                    StAsm: begin
                        data_d  = bus.i_data;
                        sof_d   = 1'b0;
                        eof_d   = 1'b0;
                        valid_d = 1'b1;
                        if (cnt_inc == CntW'(ASM_SYMS)) begin
                            state_d = StPayload;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    StPayload: begin
                        data_d  = bypass_q ? bus.i_data : (bus.i_data ^ i_r);
                        sof_d   = 1'b0;
                        valid_d = 1'b1;
                        if (cnt_inc == CntW'(PAYLOAD_SYMS)) begin
                            eof_d   = 1'b1;
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            eof_d = 1'b0;
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bypass_q      <= 1'b0;
            rst_pending_q <= 1'b1;
            data_q        <= 2'b00;
            sof_q         <= 1'b0;
            eof_q         <= 1'b0;
            valid_q       <= 1'b0;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bypass_q      <= bypass_d;
            rst_pending_q <= 1'b0;
            data_q        <= data_d;
            sof_q         <= sof_d;
            eof_q         <= eof_d;
            valid_q       <= valid_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: doc/frame_scrambler.md
Name: frame_scrambler

Overview:
- Downstream consumer of the 2-bit CCSDS pseudo-randomizer output.
- Receives a framed stream of 2-bit channel symbols. Passes each frame's attached sync marker (ASM) through unchanged, then XORs every payload symbol with the randomizer symbol.
- Drives the randomizer's reset and enable so that each frame's payload starts at the randomizer's initial state.
- Valid/ready on both sides; single registered output stage.

Parameters:
- ASM_SYMS, 16, number of 2-bit ASM symbols per frame (32-bit ASM); passed unscrambled; must be >= 1.
- PAYLOAD_SYMS, 1024, number of 2-bit payload symbols per frame; scrambled; must be >= 1.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_data, input, 2, input symbol.
- i_sof, input, 1, marks the first ASM symbol of a frame; qualified by i_valid.
- i_bypass, input, 1, disable scrambling for the frame; sampled on the accepted sof symbol only.
- i_valid, input, 1, input symbol valid.
- o_ready, output, 1, block can accept an input symbol.
- i_r, input, 2, current randomizer symbol (combinational from randomizer state).
- o_rand_rst, output, 1, synchronous reset request to the randomizer.
- o_rand_en, output, 1, advance the randomizer one step at this clock edge.
- o_data, output, 2, output symbol.
- o_sof, output, 1, first output symbol of a frame.
- o_eof, output, 1, last payload symbol of a frame.
- o_valid, output, 1, output symbol valid.
- i_ready, input, 1, downstream accepts the output.
- o_drop, output, 1, one-cycle pulse: an input symbol was discarded in IDLE.
- o_sof_err, output, 1, one-cycle pulse: sof arrived before the current frame completed.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - State IDLE, counter 0, bypass_q 0.
  - o_valid 0, o_data 0, o_sof 0, o_eof 0, o_drop 0, o_sof_err 0.
  - rst_pending 1.
- Handshake:
  - o_ready = !o_valid | i_ready.
  - accept = i_valid & o_ready.
  - The output register loads on accept; o_valid clears when i_ready is high and there is no accept.
  - Latency is 1 cycle. Full throughput is 1 symbol/cycle.
  - Output is held stable while o_valid & !i_ready.
- States:
  - IDLE: an accepted symbol with i_sof goes to ASM, output it with o_sof=1, counter=1, latch bypass_q=i_bypass. If ASM_SYMS==1, go directly to PAYLOAD, counter=0. An accepted symbol without i_sof is discarded (not output), pulses o_drop, and the state stays IDLE.
  - ASM: each accepted symbol is output unchanged. When counter reaches ASM_SYMS, go to PAYLOAD and set counter=0.
  - PAYLOAD: each accepted symbol is output as i_data ^ i_r, or i_data unchanged if bypass_q. The accepted symbol that makes counter == PAYLOAD_SYMS is output with o_eof=1, and the state goes to IDLE.
- Randomizer control (combinational outputs):
  - o_rand_en = accept & (state==PAYLOAD) & !bypass_q & !(i_sof).
  - o_rand_rst = (accept & i_sof) | rst_pending. rst_pending clears on the first i_clk edge after reset release.
  - The randomizer never advances during ASM, so the first payload symbol uses the initial randomizer state.
- Simultaneous and boundary events:
  - i_sof accepted in ASM or PAYLOAD: pulse o_sof_err; abandon the current frame (no o_eof emitted); restart as a new frame in ASM with this symbol as ASM symbol 1 and o_sof=1; assert o_rand_rst.
  - i_sof on the symbol that would be the last payload symbol: treated as a restart (sof wins); o_eof is not emitted.
  - Counter width is $clog2(max(ASM_SYMS,PAYLOAD_SYMS)+1). It never wraps: transitions occur exactly at the limits.
  - Output stall (i_ready=0): no accept, the randomizer does not advance, and the counter holds.
  - i_bypass changes mid-frame: ignored until the next accepted sof.
  - Async reset mid-frame: the frame is discarded immediately, outputs return to reset values, and the randomizer is reset on the next edge via rst_pending.

Test Plan (use a stub randomizer model unless stated):
1. ASM_SYMS=2, PAYLOAD_SYMS=3, stub i_r=2'b10, input sof+{11,11}, payload {01,00,11} with i_ready=1 -> output {11,11,11,10,01}; o_sof on the 1st output, o_eof on the 5th; o_rand_en high for 3 cycles; o_rand_rst high on the sof accept cycle.
2. Same frame with i_bypass=1 on sof -> payload output {01,00,11} unchanged; o_rand_en never asserted.
3. i_ready toggled 1,0,0,1 during payload -> o_data/o_valid held during stall; o_rand_en low while stalled; final output sequence identical to scenario 1.
4. Three symbols with no sof in IDLE, then a valid frame -> three o_drop pulses, no o_valid for the dropped symbols, then scenario 1 output.
5. sof injected at payload symbol 2 -> o_sof_err pulse; no o_eof for the aborted frame; new frame output starts with o_sof=1; o_rand_rst asserted.
6. Real randomizer connected, two back-to-back frames -> payload scrambled symbol sequences are identical for both frames; i_rst_n pulsed mid-frame -> o_valid=0 immediately, o_rand_rst=1 on the first edge after release.
